context_fetcher: RTL and testbench

- Dual-context instruction fetcher that sits directly upstream of the two-context core scheduler.
- Reads the scheduler's core_state, active_context and current_pc. Returns fetcher_state and the active context's instruction to the scheduler and decoder.
- Keeps one instruction buffer per context (A=0, B=1). A fetch still outstanding when the scheduler switches contexts completes into its originating context's buffer.
- Single outstanding request on a valid/ready program-memory port.

---
 rtl/context_fetcher_pkg.sv | 18 +
 rtl/context_fetcher_buffer.sv | 36 +++
 rtl/context_fetcher.sv | 76 +++++++
 tb/tb_context_fetcher.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/context_fetcher_pkg.sv
// context_fetcher_pkg: shared state encodings and context ids for the dual-context fetcher
package context_fetcher_pkg;
    localparam logic [2:0] CORE_IDLE   = 3'b000;
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_UPDATE = 3'b110;
    localparam logic [2:0] CORE_DONE   = 3'b111;
    localparam logic CTX_A = 1'b0;
    localparam logic CTX_B = 1'b1;
    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;
    typedef enum logic {
        REQ_READY = 1'b0,
        REQ_BUSY  = 1'b1
    } req_state_t;
endpackage

// File: rtl/context_fetcher_buffer.sv
// fetch_ctx_buffer: one context's instruction buffer with tag compare
module fetch_ctx_buffer
    import context_fetcher_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_tag,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] pc,
    output logic                 hit,
    output logic [DATA_BITS-1:0] inst
);
    logic                 valid;
    logic [ADDR_BITS-1:0] tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            tag   <= '0;
            inst  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            inst  <= wr_data;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

    assign hit = valid && tag == pc;
endmodule

// File: rtl/context_fetcher.sv
// context_fetcher: per-context instruction buffers behind a single-outstanding program memory port
module context_fetcher
    import context_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic                             active_context,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data
);
    req_state_t                       state, state_next;
    logic                             req_ctx;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_addr;
    logic [1:0]                       hit_vec;
    logic [PROGRAM_MEM_DATA_BITS-1:0] inst_vec [2];
    logic                             hit, issue, done;

    for (genvar c = 0; c < 2; c++) begin : g_buf
        fetch_ctx_buffer #(
            .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
            .DATA_BITS(PROGRAM_MEM_DATA_BITS)
        ) u_buf (
            .clk    (clk),
            .reset  (reset),
            .clr    (issue && active_context == (c == 0 ? CTX_A : CTX_B)),
            .wr_en  (done && req_ctx == (c == 0 ? CTX_A : CTX_B)),
            .wr_tag (req_addr),
            .wr_data(mem_read_data),
            .pc     (current_pc),
            .hit    (hit_vec[c]),
            .inst   (inst_vec[c])
        );
    end

    assign hit   = hit_vec[active_context];
    // Issue is gated on READY, so the completing edge can never also issue: one-cycle bubble.
    assign issue = state == REQ_READY && core_state == CORE_FETCH && !hit;
    assign done  = state == REQ_BUSY && mem_read_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= REQ_READY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == REQ_READY) state_next = issue ? REQ_BUSY : REQ_READY;
        else                    state_next = done ? REQ_READY : REQ_BUSY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ctx  <= CTX_A;
            req_addr <= '0;
        end else if (issue) begin
            req_ctx  <= active_context;
            req_addr <= current_pc;
        end
    end

    assign mem_read_valid   = state == REQ_BUSY;
    assign mem_read_address = req_addr;
    assign instruction      = inst_vec[active_context];
    assign fetcher_state    = (core_state == CORE_FETCH && hit) ? FETCHER_FETCHED
                            : (mem_read_valid && req_ctx == active_context) ? FETCHER_FETCHING
                            : FETCHER_IDLE;
endmodule

// File: tb/tb_context_fetcher.sv
// tb_context_fetcher: directed sequences plus a table of post-fetch vectors for context_fetcher
module tb_context_fetcher;
    localparam logic [2:0] FS_IDLE = 3'd0, FS_FETCHING = 3'd1, FS_FETCHED = 3'd2;
    localparam logic [2:0] C_IDLE = 3'd0, C_FETCH = 3'd1, C_DECODE = 3'd2, C_UPDATE = 3'd6, C_DONE = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  core_state = C_IDLE;
    logic        active_context = 1'b0;
    logic [7:0]  current_pc = 8'h00;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready = 1'b0;
    logic [15:0] mem_read_data = 16'h0000;

    int n_chk = 0;
    int n_fail = 0;

    context_fetcher dut (
        .clk             (clk),
        .reset           (reset),
        .core_state      (core_state),
        .active_context  (active_context),
        .current_pc      (current_pc),
        .fetcher_state   (fetcher_state),
        .instruction     (instruction),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cs;
        logic        ctx;
        logic [7:0]  pc;
        logic        rdy;
        logic [15:0] data;
        logic [2:0]  exp_state;
        logic [15:0] exp_inst;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] cs, input logic ctx, input logic [7:0] pc);
        core_state = cs;
        active_context = ctx;
        current_pc = pc;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        vecs[0] = '{C_FETCH,  1'b0, 8'h07, 1'b0, 16'h0000, FS_FETCHED, 16'h0707};
        vecs[1] = '{C_FETCH,  1'b1, 8'h07, 1'b0, 16'h0000, FS_FETCHED, 16'h1707};
        vecs[2] = '{C_DECODE, 1'b0, 8'h07, 1'b0, 16'h0000, FS_IDLE,    16'h0707};
        vecs[3] = '{C_UPDATE, 1'b1, 8'h07, 1'b0, 16'h0000, FS_IDLE,    16'h1707};
        vecs[4] = '{C_DONE,   1'b0, 8'h99, 1'b1, 16'hFFFF, FS_IDLE,    16'h0707};
        vecs[5] = '{C_IDLE,   1'b1, 8'h00, 1'b1, 16'hEEEE, FS_IDLE,    16'h1707};
        vecs[6] = '{C_FETCH,  1'b0, 8'h07, 1'b0, 16'h0000, FS_FETCHED, 16'h0707};
        vecs[7] = '{C_FETCH,  1'b1, 8'h07, 1'b0, 16'h0000, FS_FETCHED, 16'h1707};

        repeat (2) nxt();
        settle();
        chk("rst_state", fetcher_state, FS_IDLE);
        chk("rst_inst", instruction, 16'h0);
        chk("rst_valid", mem_read_valid, 1'b0);
        chk("rst_addr", mem_read_address, 8'h0);
        nxt();
        reset = 1'b1;

        // ctx0 miss at 0x05, ready three cycles after valid
        nxt();
        drive(C_FETCH, 1'b0, 8'h05);
        settle();
        chk("a_issue_state", fetcher_state, FS_IDLE);
        chk("a_issue_valid", mem_read_valid, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            nxt();
            mem_read_ready = (k == 4);
            mem_read_data = (k == 4) ? 16'h1234 : 16'h0000;
            settle();
            chk($sformatf("a_state_c%0d", k), fetcher_state, k < 5 ? FS_FETCHING : FS_FETCHED);
            chk($sformatf("a_valid_c%0d", k), mem_read_valid, k < 5);
            if (k < 5) chk($sformatf("a_addr_c%0d", k), mem_read_address, 8'h05);
        end
        chk("a_inst", instruction, 16'h1234);
        mem_read_ready = 1'b0;

        // same pc again: immediate hit, no memory traffic
        nxt();
        drive(C_DECODE, 1'b0, 8'h05);
        nxt();
        drive(C_FETCH, 1'b0, 8'h05);
        settle();
        chk("b_state", fetcher_state, FS_FETCHED);
        chk("b_inst", instruction, 16'h1234);
        nxt();
        settle();
        chk("b_valid", mem_read_valid, 1'b0);

        // ctx0 misses 0x10, scheduler switches to ctx1 before the response
        drive(C_FETCH, 1'b0, 8'h10);
        nxt();
        drive(C_DECODE, 1'b1, 8'h30);
        settle();
        chk("c_other_state", fetcher_state, FS_IDLE);
        chk("c_valid", mem_read_valid, 1'b1);
        chk("c_addr", mem_read_address, 8'h10);
        nxt();
        mem_read_ready = 1'b1;
        mem_read_data = 16'hBEEF;
        nxt();
        mem_read_ready = 1'b0;
        settle();
        chk("c_bufb_inst", instruction, 16'h0000);
        nxt();
        drive(C_FETCH, 1'b0, 8'h10);
        settle();
        chk("c_return_state", fetcher_state, FS_FETCHED);
        chk("c_return_inst", instruction, 16'hBEEF);
        chk("c_return_valid", mem_read_valid, 1'b0);

        // ctx1 misses while ctx0 owns the port; bubble before ctx1 issues
        nxt();
        drive(C_FETCH, 1'b0, 8'h40);
        nxt();
        drive(C_FETCH, 1'b1, 8'h20);
        settle();
        chk("d_blocked_state1", fetcher_state, FS_IDLE);
        chk("d_addr_a", mem_read_address, 8'h40);
        nxt();
        mem_read_ready = 1'b1;
        mem_read_data = 16'h4444;
        settle();
        chk("d_blocked_state2", fetcher_state, FS_IDLE);
        nxt();
        mem_read_ready = 1'b0;
        settle();
        chk("d_bubble_valid", mem_read_valid, 1'b0);
        chk("d_bubble_state", fetcher_state, FS_IDLE);
        nxt();
        settle();
        chk("d_b_valid", mem_read_valid, 1'b1);
        chk("d_b_addr", mem_read_address, 8'h20);
        chk("d_b_state", fetcher_state, FS_FETCHING);
        mem_read_ready = 1'b1;
        mem_read_data = 16'h2020;
        nxt();
        mem_read_ready = 1'b0;
        settle();
        chk("d_b_fetched", fetcher_state, FS_FETCHED);
        chk("d_b_inst", instruction, 16'h2020);
        drive(C_FETCH, 1'b0, 8'h40);
        #1;
        chk("d_a_hit", fetcher_state, FS_FETCHED);
        chk("d_a_inst", instruction, 16'h4444);

        // asynchronous reset while a request is outstanding
        nxt();
        drive(C_FETCH, 1'b0, 8'h07);
        nxt();
        settle();
        chk("e_valid_pre", mem_read_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("e_valid_async", mem_read_valid, 1'b0);
        chk("e_inst_async", instruction, 16'h0000);
        mem_read_ready = 1'b1;
        mem_read_data = 16'hAAAA;
        repeat (2) nxt();
        settle();
        chk("e_state_rst", fetcher_state, FS_IDLE);
        chk("e_inst_rst", instruction, 16'h0000);
        mem_read_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("e_state_post", fetcher_state, FS_IDLE);
        chk("e_inst_post", instruction, 16'h0000);

        // same pc in both contexts needs one request each (ready with N=0)
        for (int c = 0; c < 2; c++) begin
            drive(C_FETCH, c[0], 8'h07);
            settle();
            chk($sformatf("f%0d_miss_state", c), fetcher_state, FS_IDLE);
            nxt();
            settle();
            chk($sformatf("f%0d_valid", c), mem_read_valid, 1'b1);
            chk($sformatf("f%0d_addr", c), mem_read_address, 8'h07);
            mem_read_ready = 1'b1;
            mem_read_data = c == 0 ? 16'h0707 : 16'h1707;
            nxt();
            mem_read_ready = 1'b0;
            settle();
            chk($sformatf("f%0d_state", c), fetcher_state, FS_FETCHED);
            chk($sformatf("f%0d_inst", c), instruction, c == 0 ? 16'h0707 : 16'h1707);
            nxt();
        end

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].cs, vecs[i].ctx, vecs[i].pc);
            mem_read_ready = vecs[i].rdy;
            mem_read_data = vecs[i].data;
            settle();
            chk($sformatf("v%0d_state", i), fetcher_state, vecs[i].exp_state);
            chk($sformatf("v%0d_inst", i), instruction, vecs[i].exp_inst);
            chk($sformatf("v%0d_valid", i), mem_read_valid, 1'b0);
            nxt();
        end
        mem_read_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
